// File: rtl/seq_chunk_adder_pkg.sv
// seq_chunk_adder shared types and helpers.
// FSM state encoding and counter sizing.
package seq_chunk_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to count 0..n-1, at least one.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/seq_chunk_adder_chunk.sv
// chunk_adder: CHUNK-bit combinational ripple adder.
// Chain of one-bit full adder cells.
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i])
                    | (a[i] & c[i])
                    | (b[i] & c[i]);
  end

  assign cout = c[CHUNK];

endmodule

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle add/sub, CHUNK bits
// per clock with a carry register between chunks.
module seq_chunk_adder
  import seq_chunk_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iStart,
  input  logic             iSub,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iC,
  output logic [WIDTH-1:0] oS,
  output logic             oC,
  output logic             oV,
  output logic             oBusy,
  output logic             oDone
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam int MSB = WIDTH - 1;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             cy_q;

  int               idx;
  logic [CHUNK-1:0] a_c;
  logic [CHUNK-1:0] b_c;
  logic [CHUNK-1:0] s_c;
  logic             co_c;
  logic [WIDTH-1:0] sum_nx;

  // Bit offset of the chunk being processed.
  always_comb begin
    idx = int'(cnt) * CHUNK;
  end

  assign a_c = a_q[idx +: CHUNK];
  assign b_c = b_q[idx +: CHUNK];

  chunk_adder #(
    .CHUNK(CHUNK)
  ) u_chunk (
    .a   (a_c),
    .b   (b_c),
    .cin (cy_q),
    .sum (s_c),
    .cout(co_c)
  );

  // Sum register with the current chunk merged in.
  always_comb begin
    sum_nx             = sum_q;
    sum_nx[idx +: CHUNK] = s_c;
  end

  // Control FSM, operand/sum registers and outputs.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state <= IDLE;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
      cy_q  <= 1'b0;
      oS    <= '0;
      oC    <= 1'b0;
      oV    <= 1'b0;
      oBusy <= 1'b0;
      oDone <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          oDone <= 1'b0;
          if (iStart) begin
            a_q   <= iA;
            b_q   <= iSub ? ~iB : iB;
            cy_q  <= iSub ? ~iC : iC;
            cnt   <= '0;
            state <= RUN;
            oBusy <= 1'b1;
          end else begin
            state <= IDLE;
            oBusy <= 1'b0;
          end
        end
        RUN: begin
          sum_q <= sum_nx;
          cy_q  <= co_c;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= DONE;
            oBusy <= 1'b0;
            oDone <= 1'b1;
            oS    <= sum_nx;
            oC    <= co_c;
            oV    <= (a_q[MSB] == b_q[MSB])
                  && (sum_nx[MSB] != a_q[MSB]);
          end
        end
        default: begin
          state <= IDLE;
          oBusy <= 1'b0;
          oDone <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: CHUNK = 1, 4, 16
// against an arithmetic reference model.
module tb_seq_chunk_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        st [3];
  logic        sb [3];
  logic        ci [3];
  logic [15:0] ai [3];
  logic [15:0] bi [3];
  logic [15:0] so [3];
  logic        co [3];
  logic        vo [3];
  logic        bo [3];
  logic        dn [3];

  seq_chunk_adder #(.WIDTH(16), .CHUNK(1)) u_c1 (
    .iClk(clk), .iRst_n(rst_n), .iStart(st[0]),
    .iSub(sb[0]), .iA(ai[0]), .iB(bi[0]), .iC(ci[0]),
    .oS(so[0]), .oC(co[0]), .oV(vo[0]),
    .oBusy(bo[0]), .oDone(dn[0])
  );

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_c4 (
    .iClk(clk), .iRst_n(rst_n), .iStart(st[1]),
    .iSub(sb[1]), .iA(ai[1]), .iB(bi[1]), .iC(ci[1]),
    .oS(so[1]), .oC(co[1]), .oV(vo[1]),
    .oBusy(bo[1]), .oDone(dn[1])
  );

  seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) u_c16 (
    .iClk(clk), .iRst_n(rst_n), .iStart(st[2]),
    .iSub(sb[2]), .iA(ai[2]), .iB(bi[2]), .iC(ci[2]),
    .oS(so[2]), .oC(co[2]), .oV(vo[2]),
    .oBusy(bo[2]), .oDone(dn[2])
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit armed = 1'b0;

  bit          pv  [3];
  int          pdue[3];
  logic [15:0] ps  [3];
  logic        pc  [3];
  logic        pvv [3];
  logic [15:0] hs  [3];
  logic        hc  [3];
  logic        hv  [3];

  function automatic int nn(input int k);
    return (k == 0) ? 16 : (k == 1) ? 4 : 1;
  endfunction

  // Returns {sum, carry/no-borrow, signed overflow}.
  function automatic logic [17:0] model(
    input logic [15:0] a, input logic [15:0] b,
    input logic c, input logic sub);
    int ua, ub, sa, sbv, cv, r, sr;
    logic [15:0] s;
    logic cc, v;
    ua  = int'(a);
    ub  = int'(b);
    sa  = int'($signed(a));
    sbv = int'($signed(b));
    cv  = c ? 1 : 0;
    if (!sub) begin
      r  = ua + ub + cv;
      cc = (r > 65535);
      sr = sa + sbv + cv;
    end else begin
      r  = ua - ub - cv;
      cc = (ua >= ub + cv);
      sr = sa - sbv - cv;
    end
    s = r[15:0];
    v = (sr > 32767) || (sr < -32768);
    return {s, cc, v};
  endfunction

  task automatic check(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  // Model: accept starts when idle, schedule the result.
  always @(posedge clk) begin
    logic [17:0] r;
    cyc++;
    if (!rst_n) begin
      armed = 1'b1;
      for (int k = 0; k < 3; k++) begin
        pv[k] = 1'b0;
        hs[k] = '0;
        hc[k] = 1'b0;
        hv[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (st[k] && !pv[k]) begin
          r       = model(ai[k], bi[k], ci[k], sb[k]);
          pv[k]   = 1'b1;
          pdue[k] = cyc + nn(k);
          ps[k]   = r[17:2];
          pc[k]   = r[1];
          pvv[k]  = r[0];
        end
      end
    end
  end

  // Compare all DUT outputs every cycle.
  always @(negedge clk) begin
    logic ed, eb;
    if (armed) begin
      for (int k = 0; k < 3; k++) begin
        ed = pv[k] && (pdue[k] == cyc);
        eb = pv[k] && (cyc < pdue[k]);
        if (ed) begin
          hs[k] = ps[k];
          hc[k] = pc[k];
          hv[k] = pvv[k];
          pv[k] = 1'b0;
        end
        tests++;
        if ({dn[k], bo[k], so[k], co[k], vo[k]} !==
            {ed, eb, hs[k], hc[k], hv[k]}) begin
          fails++;
          $display("FAIL cmp%0d cyc %0d got %h exp %h",
                   k, cyc,
                   {dn[k], bo[k], so[k], co[k], vo[k]},
                   {ed, eb, hs[k], hc[k], hv[k]});
        end
      end
    end
  end

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    #1;
    while (pv[k] && n < 64) begin
      @(negedge clk);
      #1;
      n++;
    end
    tests++;
    if (pv[k]) begin
      fails++;
      $display("FAIL timeout%0d got busy exp done", k);
    end
  endtask

  task automatic run_op(input int k,
                        input logic [15:0] a,
                        input logic [15:0] b,
                        input logic c,
                        input logic sub);
    @(negedge clk);
    ai[k] = a;
    bi[k] = b;
    ci[k] = c;
    sb[k] = sub;
    st[k] = 1'b1;
    @(negedge clk);
    st[k] = 1'b0;
    wait_idle(k);
  endtask

  initial begin
    logic [15:0] ra, rb;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      st[k] = 1'b0;
      sb[k] = 1'b0;
      ci[k] = 1'b0;
      ai[k] = '0;
      bi[k] = '0;
    end
    repeat (3) @(negedge clk);
    check("rst_out", {14'd0, so[1], co[1], vo[1], bo[1], dn[1]}, 32'd0);
    rst_n = 1'b1;

    check("pin_add", 32'(model(16'h1234, 16'h4321, 1'b0, 1'b0)),
          32'({16'h5555, 1'b0, 1'b0}));
    check("pin_cy", 32'(model(16'hFFFF, 16'h0001, 1'b0, 1'b0)),
          32'({16'h0000, 1'b1, 1'b0}));
    check("pin_ov", 32'(model(16'h7FFF, 16'h0001, 1'b0, 1'b0)),
          32'({16'h8000, 1'b0, 1'b1}));
    check("pin_bw", 32'(model(16'h0005, 16'h0007, 1'b0, 1'b1)),
          32'({16'hFFFE, 1'b0, 1'b0}));
    check("pin_sov", 32'(model(16'h8000, 16'h0001, 1'b0, 1'b1)),
          32'({16'h7FFF, 1'b1, 1'b1}));

    run_op(1, 16'h1234, 16'h4321, 1'b0, 1'b0);
    check("t1", {14'd0, so[1], co[1], vo[1]}, {14'd0, 16'h5555, 2'b00});
    run_op(1, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    check("t2a", {14'd0, so[1], co[1], vo[1]}, {14'd0, 16'h0000, 2'b10});
    run_op(1, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    check("t2b", {14'd0, so[1], co[1], vo[1]}, {14'd0, 16'h8000, 2'b01});
    run_op(1, 16'h0005, 16'h0007, 1'b0, 1'b1);
    check("t3a", {14'd0, so[1], co[1], vo[1]}, {14'd0, 16'hFFFE, 2'b00});
    run_op(1, 16'h8000, 16'h0001, 1'b0, 1'b1);
    check("t3b", {14'd0, so[1], co[1], vo[1]}, {14'd0, 16'h7FFF, 2'b11});

    // Start held high, operands changing mid-run.
    @(negedge clk);
    ai[1] = 16'h0100;
    bi[1] = 16'h0023;
    ci[1] = 1'b1;
    sb[1] = 1'b0;
    st[1] = 1'b1;
    repeat (16) begin
      @(negedge clk);
      ai[1] = 16'($urandom);
      bi[1] = 16'($urandom);
    end
    st[1] = 1'b0;
    wait_idle(1);

    // Start pulse while busy must be ignored.
    @(negedge clk);
    ai[1] = 16'h0F0F;
    bi[1] = 16'h0101;
    ci[1] = 1'b0;
    sb[1] = 1'b0;
    st[1] = 1'b1;
    @(negedge clk);
    st[1] = 1'b0;
    @(negedge clk);
    ai[1] = 16'hAAAA;
    st[1] = 1'b1;
    @(negedge clk);
    st[1] = 1'b0;
    wait_idle(1);
    check("ign", {14'd0, so[1], co[1], vo[1]}, {14'd0, 16'h1010, 2'b00});

    // Reset in the third RUN cycle aborts the operation.
    @(negedge clk);
    ai[1] = 16'h1111;
    bi[1] = 16'h2222;
    st[1] = 1'b1;
    @(negedge clk);
    st[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort", {14'd0, so[1], co[1], vo[1], bo[1], dn[1]}, 32'd0);
    repeat (6) @(negedge clk);
    run_op(1, 16'h1111, 16'h2222, 1'b1, 1'b0);
    check("fresh", {14'd0, so[1], co[1], vo[1]}, {14'd0, 16'h3334, 2'b00});

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 1000; i++) begin
        ra = 16'($urandom);
        rb = 16'($urandom);
        if (i % 8 == 0) ra = 16'h7FFF ^ 16'($urandom_range(0, 1));
        run_op(k, ra, rb, 1'($urandom), 1'($urandom));
      end
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
